serial_pattern_tx: RTL
======================

// Module: serial_pattern_tx
// PURPOSE
// - Transmit side of the single-bit serial pattern link; drives the x input of the sequence detectors (even/odd-ones, consecutive-00).
// - Accepts a parallel word over valid/ready and shifts it out MSB-first, one bit per clk.
// - Keeps a running ones-parity and "00"-pair count over the bits sent. A checker compares these against the detector output.
// PARAMETERS
// - WIDTH       8  maximum bits per word; LW = $clog2(WIDTH+1)
// - GAP_CYCLES  2  idle cycles (x=1) inserted after each word; 0 allowed
// - CNT_W       4  width of zz_count, saturating
// PORTS
// - clk          in   1      rising-edge clock
// - reset_n      in   1      asynchronous active-low reset
// - data_in      in   WIDTH  word, MSB-aligned: data_in[WIDTH-1] is sent first
// - len_in       in   LW     number of bits to send, 0..WIDTH
// - in_valid     in   1      data_in/len_in valid
// - in_ready     out  1      block can accept a word (IDLE only)
// - x            out  1      serial bit; idles at 1
// - x_valid      out  1      x carries a payload bit this cycle
// - busy         out  1      state != IDLE
// - done         out  1      one-cycle pulse, word finished
// - ones_parity  out  1      XOR of all payload bits sent since last accept
// - zz_count     out  CNT_W  count of adjacent 0,0 payload pairs since last accept
// BEHAVIOUR
// - Reset values (async, immediate, including mid-word):
//   - x=1, x_valid=0, in_ready=1, busy=0, done=0, ones_parity=0, zz_count=0
//   - state=IDLE; shift and bit counters cleared
// - All outputs registered. States: IDLE, SHIFT, GAP.
// - IDLE: in_ready=1.
//   - Handshake = in_valid & in_ready at an edge.
//   - len_in>0: at that edge, shreg<=data_in<<1, x<=data_in[WIDTH-1], x_valid<=1, bitcnt<=len_in-1, go SHIFT.
//   - Stats cleared at accept, then updated with the first bit.
//   - First bit is visible the cycle after the handshake.
//   - len_in=0: no bits sent, stats cleared, done=1 next cycle.
//     - Go GAP if GAP_CYCLES>0, else stay IDLE.
//   - len_in>WIDTH: clamp to WIDTH.
// - SHIFT: each edge with bitcnt>0: x<=shreg[WIDTH-1], shift left, bitcnt--, update stats.
//   - When bitcnt=0 at an edge (last bit was on x this cycle):
//     - x<=1, x_valid<=0, done<=1 (pulse)
//     - go GAP (GAP_CYCLES>0) or IDLE
// - GAP: x=1, x_valid=0, in_ready=0 for exactly GAP_CYCLES cycles, then IDLE.
// - Minimum spacing between the last bit of one word and the first bit of the next is GAP_CYCLES+1 cycles.
// - Stats, evaluated on each payload bit b:
//   - ones_parity ^= b
//   - zz_count++ if b=0 and the previous payload bit of the same word is 0
//   - prev-bit is set to 1 at accept, so pairs never span words
//   - zz_count saturates at 2^CNT_W-1
// - Stats hold their value after done until the next accept.
// - in_valid/data_in are ignored outside IDLE; no buffering.
// STRUCTURE
// - Shared header serial_link_defs.vh:
//   - state encodings (IDLE=2'd0, SHIFT=2'd1, GAP=2'd2)
//   - X_IDLE=1'b1 idle line level
//   - default WIDTH
// - One sub-module: serial_run_stats (parity + saturating 00 counter). Inputs: bit, bit_en, clear.
//   The receiver-side checker reuses it.
// - The remaining logic (FSM, shift register, counters) stays in this module.
// TESTING
// - Use WIDTH=8, GAP_CYCLES=2, CNT_W=4 unless noted.
// 1. Reset held 3 cycles with in_valid=1:
//    -> x=1, x_valid=0, in_ready=1, busy=0, stats 0, nothing accepted.
// 2. Send data 8'hD1, len 8:
//    -> x = 1,1,0,1,0,0,0,1 on cycles 1..8 after handshake, x_valid=1 throughout.
//    -> done on cycle 9, then x=1 for 2 gap cycles, in_ready=1 on cycle 11.
//    -> ones_parity=0, zz_count=2.
// 3. 8'hD1 then 8'h8C sent as soon as in_ready:
//    -> second word x = 1,0,0,0,1,1,0,0.
//    -> ones_parity=1, zz_count=3 (per-word; stats cleared at second accept).
// 4. data 8'h20, len 3:
//    -> x = 0,0,1, done on the 4th cycle, parity=1, zz_count=1.
//    -> len 0 -> no x_valid, done on the next cycle, stats 0.
// 5. reset_n low during the 4th bit of 8'hD1:
//    -> same cycle x=1, x_valid=0, busy=0, stats 0, no done pulse.
//    -> after release, a new word transmits normally.
// 6. data 8'h00, len 8, CNT_W=2:
//    -> zz_count saturates at 3, parity=0.
//    -> in_valid with different data held during SHIFT is not accepted.

Source files
------------

// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for the serial pattern link: FSM state encoding,
// idle line level and the default word width.
package serial_pattern_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam logic X_IDLE        = 1'b1;
   localparam int   DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_run_stats.sv
// Running statistics over a serial payload stream: ones-parity and a
// saturating count of adjacent 0,0 pairs. A clear restarts a word; a bit
// presented together with the clear counts as the first bit of the new word.
// The receiver-side checker instantiates this same block.
module serial_run_stats
   import serial_pattern_tx_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             bit_val,
   input  logic             bit_en,
   input  logic             clear,
   output logic             ones_parity,
   output logic [CNT_W-1:0] zz_count
);

   localparam logic [CNT_W-1:0] ZZ_MAX = '1;

   // previous payload bit of the current word; 1 after a clear so that
   // pairs never span two words
   logic prev_bit;

   // parity / pair counter update, restarted by clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ones_parity <= 1'b0;
         zz_count    <= '0;
         prev_bit    <= 1'b1;
      end else if (clear) begin
         ones_parity <= bit_en & bit_val;
         zz_count    <= '0;
         prev_bit    <= bit_en ? bit_val : 1'b1;
      end else if (bit_en) begin
         ones_parity <= ones_parity ^ bit_val;
         if (!bit_val && !prev_bit && (zz_count != ZZ_MAX))
            zz_count <= zz_count + 1'b1;
         prev_bit <= bit_val;
      end
   end

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: accepts a parallel word over valid/ready and
// shifts it out MSB-first on x, one bit per clock, followed by an idle gap.
//
// state    | meaning
// ST_IDLE  | line idle (x=1), in_ready=1, waiting for a word
// ST_SHIFT | payload bits on x, bitcnt = bits still to follow
// ST_GAP   | inter-word idle (x=1) for GAP_CYCLES cycles
module serial_pattern_tx
   import serial_pattern_tx_pkg::*;
#(
   parameter  int WIDTH      = DEFAULT_WIDTH,
   parameter  int GAP_CYCLES = 2,
   parameter  int CNT_W      = 4,
   localparam int LW         = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic [LW-1:0]    len_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             done,
   output logic             ones_parity,
   output logic [CNT_W-1:0] zz_count
);

   localparam int             GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0]  GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [LW-1:0]  LEN_MAX  = LW'(WIDTH);

   state_t           state, state_nx;
   logic [WIDTH-1:0] shreg, shreg_nx;
   logic [LW-1:0]    bitcnt, bitcnt_nx;
   logic [GW-1:0]    gapcnt, gapcnt_nx;
   logic             x_nx, x_valid_nx, done_nx;
   logic [LW-1:0]    len_eff;
   logic             handshake;
   logic             stat_bit, stat_en, stat_clr;

   assign handshake = in_valid & in_ready;

   // state register and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         shreg    <= '0;
         bitcnt   <= '0;
         gapcnt   <= '0;
         x        <= X_IDLE;
         x_valid  <= 1'b0;
         done     <= 1'b0;
         in_ready <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_nx;
         shreg    <= shreg_nx;
         bitcnt   <= bitcnt_nx;
         gapcnt   <= gapcnt_nx;
         x        <= x_nx;
         x_valid  <= x_valid_nx;
         done     <= done_nx;
         in_ready <= (state_nx == ST_IDLE);
         busy     <= (state_nx != ST_IDLE);
      end
   end

   // next-state, datapath and stats strobes
   always_comb begin
      state_nx   = state;
      shreg_nx   = shreg;
      bitcnt_nx  = bitcnt;
      gapcnt_nx  = gapcnt;
      x_nx       = x;
      x_valid_nx = x_valid;
      done_nx    = 1'b0;
      stat_bit   = shreg[WIDTH-1];
      stat_en    = 1'b0;
      stat_clr   = 1'b0;
      len_eff    = (len_in > LEN_MAX) ? LEN_MAX : len_in;

      case (state)
         ST_IDLE: begin
            x_nx       = X_IDLE;
            x_valid_nx = 1'b0;
            if (handshake) begin
               stat_clr = 1'b1;
               if (len_eff != '0) begin
                  shreg_nx   = data_in << 1;
                  x_nx       = data_in[WIDTH-1];
                  x_valid_nx = 1'b1;
                  bitcnt_nx  = len_eff - 1'b1;
                  stat_bit   = data_in[WIDTH-1];
                  stat_en    = 1'b1;
                  state_nx   = ST_SHIFT;
               end else begin
                  // empty word: finish at once, still honour the gap
                  done_nx = 1'b1;
                  if (GAP_CYCLES > 0) begin
                     state_nx  = ST_GAP;
                     gapcnt_nx = GAP_LOAD;
                  end
               end
            end
         end
         ST_SHIFT: begin
            if (bitcnt != '0) begin
               x_nx      = shreg[WIDTH-1];
               shreg_nx  = shreg << 1;
               bitcnt_nx = bitcnt - 1'b1;
               stat_en   = 1'b1;
            end else begin
               x_nx       = X_IDLE;
               x_valid_nx = 1'b0;
               done_nx    = 1'b1;
               if (GAP_CYCLES > 0) begin
                  state_nx  = ST_GAP;
                  gapcnt_nx = GAP_LOAD;
               end else begin
                  state_nx = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            x_nx       = X_IDLE;
            x_valid_nx = 1'b0;
            if (gapcnt == '0)
               state_nx = ST_IDLE;
            else
               gapcnt_nx = gapcnt - 1'b1;
         end
         default: begin
            state_nx   = ST_IDLE;
            x_nx       = X_IDLE;
            x_valid_nx = 1'b0;
         end
      endcase
   end

   serial_run_stats #(
      .CNT_W (CNT_W)
   ) u_stats (
      .clk         (clk),
      .reset_n     (reset_n),
      .bit_val     (stat_bit),
      .bit_en      (stat_en),
      .clear       (stat_clr),
      .ones_parity (ones_parity),
      .zz_count    (zz_count)
   );

endmodule
